// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steps the PC register, issues imem requests and
// hands fetched words to decode, handling redirects and squashed responses.
module fetch_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] curr_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_en,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            drop_q, drop_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Next-state and PC-update logic; a redirect always wins the PC load.
  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    pc_en        = 1'b0;
    next_pc      = '0;

    if (redirect_valid) begin
      pc_en   = 1'b1;
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end

    unique case (state_q)
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (drop_q) begin
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end
        end else if (imem_resp_valid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            inst_data_d  = imem_resp_data;
            inst_pc_d    = curr_pc;
            inst_valid_d = 1'b1;
            pc_en        = 1'b1;
            next_pc      = curr_pc + XLEN'(PC_INC);
            state_d      = S_OUT;
          end
        end else if (redirect_valid) begin
          // Response for the old PC is still in flight and must be swallowed.
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Gate the request with redirect so a stale curr_pc is never issued.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = curr_pc;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: owns the PC register and imem, compares the
// DUT every cycle against a transaction-level model, plus directed literal checks.
module tb_fetch_ctrl;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] KEY  = 32'hA5A5A5A5;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] curr_pc;
  logic [XLEN-1:0] next_pc;
  logic            pc_en;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  always #5 clk = ~clk;

  fetch_ctrl #(.XLEN(32), .PC_INC(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .curr_pc         (curr_pc),
    .next_pc         (next_pc),
    .pc_en           (pc_en),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready)
  );

  // PC register on the far side of next_pc/pc_en
  always @(posedge clk) begin
    if (reset) curr_pc <= '0;
    else if (pc_en) curr_pc <= next_pc;
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: outstanding fetch, whether it is squashed, held instruction, PC.
  bit          m_busy, m_stale, m_have;
  logic [31:0] m_hpc, m_hdata, m_pc;

  // imem model
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat = 1;
  bit          late;

  logic [31:0] acc_q[$], pcen_q[$], ipc_q[$], idata_q[$];
  logic        obs_req_valid, obs_inst_valid, obs_pc_en;
  logic [31:0] obs_next_pc, obs_inst_pc, obs_inst_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] at_q(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic clear_logs();
    acc_q.delete(); pcen_q.delete(); ipc_q.delete(); idata_q.delete();
  endtask

  // One clock: drive imem response, compare at negedge, advance model, return at posedge+1.
  task automatic step();
    bit          idle, e_req, e_en, rsp;
    logic [31:0] e_npc, old_pc;
    imem_resp_valid = late || (pend && pend_wait == 0);
    imem_resp_data  = late ? 32'hDEADBEEF : (pend_addr ^ KEY);
    @(negedge clk);
    rsp   = imem_resp_valid;
    idle  = !m_busy && !m_have;
    e_req = idle && !redirect_valid;
    e_en  = 1'b0;
    e_npc = 32'h0;
    if (redirect_valid) begin
      e_en  = 1'b1;
      e_npc = {redirect_pc[31:2], 2'b00};
    end else if (m_busy && !m_stale && rsp) begin
      e_en  = 1'b1;
      e_npc = m_pc + 32'd4;
    end
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, e_req});
    chk("req_addr", imem_req_addr, m_pc);
    chk("pc_en", {31'd0, pc_en}, {31'd0, e_en});
    chk("next_pc", next_pc, e_npc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
    chk("inst_pc", inst_pc, m_hpc);
    chk("inst_data", inst_data, m_hdata);

    if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
    if (pc_en) pcen_q.push_back(next_pc);
    if (inst_valid && inst_ready) begin
      ipc_q.push_back(inst_pc);
      idata_q.push_back(inst_data);
    end
    obs_req_valid  = imem_req_valid;
    obs_inst_valid = inst_valid;
    obs_pc_en      = pc_en;
    obs_next_pc    = next_pc;
    obs_inst_pc    = inst_pc;
    obs_inst_data  = inst_data;

    old_pc = m_pc;
    if (reset) begin
      m_busy = 0; m_stale = 0; m_have = 0;
      m_hpc = 0; m_hdata = 0; m_pc = 0;
    end else begin
      if (redirect_valid) begin
        m_have = 0;
        if (m_busy) begin
          if (rsp) begin m_busy = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        if (m_have && inst_ready) m_have = 0;
        if (m_busy && rsp) begin
          if (!m_stale) begin
            m_have  = 1;
            m_hpc   = old_pc;
            m_hdata = imem_resp_data;
          end
          m_busy  = 0;
          m_stale = 0;
        end else if (idle && imem_req_ready) begin
          m_busy  = 1;
          m_stale = 0;
        end
      end
      if (e_en) m_pc = e_npc;
    end

    if (reset) pend = 0;
    else if (rsp && !late) pend = 0;
    else if (pend) pend_wait--;
    if (!reset && imem_req_valid && imem_req_ready) begin
      pend      = 1;
      pend_addr = imem_req_addr;
      pend_wait = lat - 1;
    end
    late = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1; redirect_valid = 0;
    repeat (n) step();
    reset = 0;
    clear_logs();
  endtask

  initial begin
    bit found;
    int n_acc;
    reset = 1; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 1; inst_ready = 1;
    imem_resp_valid = 0; imem_resp_data = 0;
    m_busy = 0; m_stale = 0; m_have = 0; m_hpc = 0; m_hdata = 0; m_pc = 0;
    pend = 0; pend_addr = 0; pend_wait = 0; late = 0;
    @(posedge clk); #1;

    // 1: reset then free-run
    do_reset(2);
    repeat (10) step();
    chk("t1_first_req", at_q(acc_q, 0), 32'h0);
    chk("t1_pc0", at_q(ipc_q, 0), 32'h0);
    chk("t1_data0", at_q(idata_q, 0), 32'hA5A5A5A5);
    chk("t1_pc1", at_q(ipc_q, 1), 32'h4);
    chk("t1_data1", at_q(idata_q, 1), 32'hA5A5A5A1);
    chk("t1_pc2", at_q(ipc_q, 2), 32'h8);
    chk("t1_data2", at_q(idata_q, 2), 32'hA5A5A5AD);
    chk("t1_npc0", at_q(pcen_q, 0), 32'h4);
    chk("t1_npc1", at_q(pcen_q, 1), 32'h8);
    chk("t1_npc2", at_q(pcen_q, 2), 32'hC);

    // 2: backpressure on pc 0x4
    do_reset(1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_have && m_hpc == 32'h4) begin found = 1; break; end
      step();
    end
    chk("t2_reach_pc4", {31'd0, found}, 32'd1);
    inst_ready = 0;
    n_acc = acc_q.size();
    repeat (5) begin
      step();
      chk("t2_hold_valid", {31'd0, obs_inst_valid}, 32'd1);
      chk("t2_hold_pc", obs_inst_pc, 32'h4);
      chk("t2_hold_data", obs_inst_data, 32'hA5A5A5A1);
    end
    chk("t2_no_new_req", acc_q.size(), n_acc);
    inst_ready = 1;
    step();
    chk("t2_consumed_pc", at_q(ipc_q, ipc_q.size() - 1), 32'h4);

    // 3: redirect while fetch of 0x8 is outstanding
    do_reset(1);
    lat = 3;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (pend && pend_addr == 32'h8) begin found = 1; break; end
      step();
    end
    chk("t3_reach_wait8", {31'd0, found}, 32'd1);
    clear_logs();
    redirect_valid = 1; redirect_pc = 32'h103;
    step();
    redirect_valid = 0;
    lat = 1;
    chk("t3_redirect_npc", at_q(pcen_q, 0), 32'h100);
    repeat (12) step();
    found = 0;
    foreach (ipc_q[i]) if (ipc_q[i] == 32'h8) found = 1;
    chk("t3_stale_dropped", {31'd0, found}, 32'd0);
    chk("t3_next_req", at_q(acc_q, 0), 32'h100);
    chk("t3_next_pc", at_q(ipc_q, 0), 32'h100);
    chk("t3_next_data", at_q(idata_q, 0), 32'hA5A5A4A5);

    // 4: redirect in REQ with req_ready high
    do_reset(1);
    redirect_valid = 1; redirect_pc = 32'h200; imem_req_ready = 1;
    step();
    redirect_valid = 0;
    chk("t4_req_gated", {31'd0, obs_req_valid}, 32'd0);
    chk("t4_npc", at_q(pcen_q, 0), 32'h200);
    repeat (4) step();
    chk("t4_next_req", at_q(acc_q, 0), 32'h200);

    // 5: redirect in OUT with decode stalled
    do_reset(1);
    inst_ready = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_have) begin found = 1; break; end
      step();
    end
    chk("t5_reach_out", {31'd0, found}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h40;
    step();
    redirect_valid = 0;
    clear_logs();
    step();
    chk("t5_valid_dropped", {31'd0, obs_inst_valid}, 32'd0);
    repeat (4) step();
    chk("t5_next_req", at_q(acc_q, 0), 32'h40);

    // 6: wrap at top of address space, then reset while in WAIT
    inst_ready = 1;
    redirect_valid = 1; redirect_pc = 32'hFFFFFFFC;
    step();
    redirect_valid = 0;
    clear_logs();
    repeat (4) step();
    chk("t6_wrap_pc", at_q(ipc_q, 0), 32'hFFFFFFFC);
    chk("t6_wrap_npc", at_q(pcen_q, 0), 32'h0);
    lat = 3;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend) begin found = 1; break; end
      step();
    end
    chk("t6_reach_wait", {31'd0, found}, 32'd1);
    reset = 1;
    step();
    reset = 0;
    lat = 1;
    late = 1;
    clear_logs();
    step();
    chk("t6_rst_inst_valid", {31'd0, obs_inst_valid}, 32'd0);
    chk("t6_rst_pc_en", {31'd0, obs_pc_en}, 32'd0);
    chk("t6_rst_next_pc", obs_next_pc, 32'h0);
    chk("t6_rst_inst_pc", obs_inst_pc, 32'h0);
    chk("t6_rst_inst_data", obs_inst_data, 32'h0);
    chk("t6_rst_req_valid", {31'd0, obs_req_valid}, 32'd1);
    repeat (4) step();
    chk("t6_after_pc", at_q(ipc_q, 0), 32'h0);
    chk("t6_after_data", at_q(idata_q, 0), 32'hA5A5A5A5);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = $urandom_range(0, 1) == 1;
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(0, 99) == 0);
      lat            = 1 + int'($urandom_range(0, 2));
      step();
    end
    reset = 0; redirect_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
